axi_rdata_recv: RTL and testbench



---
 rtl/axi_rdata_recv.sv | 119 +++++++++++
 tb/tb_axi_rdata_recv.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rdata_recv.sv
// AXI R-channel receiver for the DMA engine: counts beats against the programmed
// transfer length, flags bad responses, and buffers data in a FWFT FIFO.
module axi_rdata_recv #(
   parameter int DATA_W  = 32,
   parameter int FIFO_AW = 4
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   input  logic                dma_axi_start,
   input  logic [13:0]         dma_cfg_number,
   output logic                dma_axi_rdata_free,
   output logic                dma_rd_err,
   output logic [DATA_W-1:0]   buf_data,
   output logic                buf_valid,
   input  logic                buf_ready,
   output logic [FIFO_AW:0]    buf_count
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state, state_next;
   logic [13:0]        remaining, remaining_next;
   logic               err_next;
   logic               push, pop;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;

   assign push = rvalid && rready;
   assign pop  = (count != '0) && buf_ready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= IDLE;
         remaining  <= '0;
         dma_rd_err <= 1'b0;
      end else begin
         state      <= state_next;
         remaining  <= remaining_next;
         dma_rd_err <= err_next;
      end
   end

   // rlast is only cross-checked against the beat count; it never ends a transfer.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      err_next       = dma_rd_err;
      rready         = 1'b0;
      case (state)
         IDLE: begin
            if (dma_axi_start) begin
               err_next = 1'b0;
               if (dma_cfg_number != '0) begin
                  remaining_next = dma_cfg_number;
                  state_next     = BUSY;
               end
            end
         end
         BUSY: begin
            rready = (count != FULL_CNT);
            if (rvalid && (count != FULL_CNT)) begin
               remaining_next = remaining - 14'd1;
               if (rresp != 2'b00)
                  err_next = 1'b1;
               if (remaining == 14'd1) begin
                  state_next = IDLE;
                  if (!rlast)
                     err_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign dma_axi_rdata_free = (state == IDLE);

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data-only; a stray write during reset is harmless since pointers clear.
   always_ff @(posedge aclk) begin
      if (push)
         mem[wr_ptr] <= rdata;
   end

   assign buf_data  = mem[rd_ptr];
   assign buf_valid = (count != '0);
   assign buf_count = count;

endmodule

// File: tb/tb_axi_rdata_recv.sv
// Scoreboard bench for axi_rdata_recv: accepted beats are queued as they are
// driven and compared in order as the consumer pops the buffer.
module tb_axi_rdata_recv;

   localparam int DATA_W  = 32;
   localparam int FIFO_AW = 4;

   logic                aclk = 1'b0;
   logic                areset;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   logic                dma_axi_start;
   logic [13:0]         dma_cfg_number;
   logic                dma_axi_rdata_free;
   logic                dma_rd_err;
   logic [DATA_W-1:0]   buf_data;
   logic                buf_valid;
   logic                buf_ready;
   logic [FIFO_AW:0]    buf_count;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   always #5 aclk = ~aclk;

   axi_rdata_recv #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
      .aclk(aclk), .areset(areset),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .dma_axi_start(dma_axi_start), .dma_cfg_number(dma_cfg_number),
      .dma_axi_rdata_free(dma_axi_rdata_free), .dma_rd_err(dma_rd_err),
      .buf_data(buf_data), .buf_valid(buf_valid), .buf_ready(buf_ready),
      .buf_count(buf_count)
   );

   // Consumer-side scoreboard: every pop must match the oldest accepted beat.
   always @(negedge aclk) begin
      if (areset === 1'b0) begin
         checks++;
         if (buf_count > 16 || buf_valid !== (buf_count != 0)) begin
            errors++;
            $display("FAIL count_range: count=%0d valid=%b", buf_count, buf_valid);
         end
         if (buf_valid === 1'b1 && buf_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_empty: got %h, expected nothing", buf_data);
            end else begin
               logic [DATA_W-1:0] e;
               e = exp_q.pop_front();
               if (buf_data !== e) begin
                  errors++;
                  $display("FAIL pop_data: got %h, expected %h", buf_data, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic start_xfer(input logic [13:0] n);
      dma_cfg_number = n;
      dma_axi_start  = 1'b1;
      tick();
      dma_axi_start  = 1'b0;
   endtask

   // Drives beats first..first+cnt-1 of a total-beat transfer; rlast on the final beat if last_ok.
   task automatic drive_beats(input int first, input int cnt, input int total,
                              input logic [DATA_W-1:0] base, input int bad,
                              input bit last_ok, input bit rnd, input int max_cyc,
                              output int cycles);
      int i;
      i = first;
      cycles = 0;
      while (i < first + cnt && cycles < max_cyc) begin
         rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rnd) buf_ready = 1'($urandom_range(0, 1));
         rdata  = base + DATA_W'(i);
         rresp  = (i + 1 == bad) ? 2'b10 : 2'b00;
         rlast  = (i == total - 1) ? last_ok : 1'b0;
         @(negedge aclk);
         if (rvalid && rready) begin
            exp_q.push_back(rdata);
            i++;
         end
         tick();
         dma_axi_start = 1'b0;
         cycles++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      checks++;
      if (i != first + cnt) begin
         errors++;
         $display("FAIL beat_timeout: accepted %0d, required %0d", i - first, cnt);
      end
   endtask

   task automatic drain();
      int n;
      rvalid = 1'b0;
      buf_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || buf_count != 0) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (buf_count !== 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: count=%0d queue=%0d, required 0/0", buf_count, exp_q.size());
      end
   endtask

   task automatic test_reset();
      areset = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      dma_axi_start = 1'b0; dma_cfg_number = '0; buf_ready = 1'b0;
      tick(); tick();
      checks++;
      if (rready !== 1'b0 || dma_axi_rdata_free !== 1'b1 || dma_rd_err !== 1'b0 ||
          buf_valid !== 1'b0 || buf_count !== 0) begin
         errors++;
         $display("FAIL reset_state: rready=%b free=%b err=%b valid=%b count=%0d, required 0 1 0 0 0",
                  rready, dma_axi_rdata_free, dma_rd_err, buf_valid, buf_count);
      end
      areset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int cyc;
      buf_ready = 1'b1;
      start_xfer(14'd5);
      checks++;
      if (dma_axi_rdata_free !== 1'b0 || rready !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: free=%b rready=%b, required 0 1", dma_axi_rdata_free, rready);
      end
      drive_beats(0, 5, 5, 32'h10, 0, 1'b1, 1'b0, 50, cyc);
      checks++;
      if (cyc != 5) begin
         errors++;
         $display("FAIL basic_cycles: took %0d cycles, required 5", cyc);
      end
      checks++;
      if (dma_axi_rdata_free !== 1'b1 || rready !== 1'b0 || dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: free=%b rready=%b err=%b, required 1 0 0",
                  dma_axi_rdata_free, rready, dma_rd_err);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int cyc;
      buf_ready = 1'b0;
      start_xfer(14'd20);
      drive_beats(0, 16, 20, 32'h100, 0, 1'b1, 1'b0, 50, cyc);
      rvalid = 1'b1; rdata = 32'h100 + 32'd16;
      tick(); tick();
      checks++;
      if (buf_count !== 16 || rready !== 1'b0 || dma_axi_rdata_free !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: count=%0d rready=%b free=%b, required 16 0 0",
                  buf_count, rready, dma_axi_rdata_free);
      end
      buf_ready = 1'b1;
      tick();
      buf_ready = 1'b0;
      checks++;
      if (buf_count !== 15 || rready !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop: count=%0d rready=%b, required 15 1", buf_count, rready);
      end
      drive_beats(16, 1, 20, 32'h100, 0, 1'b1, 1'b0, 5, cyc);
      checks++;
      if (cyc != 1 || buf_count !== 16) begin
         errors++;
         $display("FAIL bp_17th: cycles=%0d count=%0d, required 1 16", cyc, buf_count);
      end
      buf_ready = 1'b1;
      drive_beats(17, 3, 20, 32'h100, 0, 1'b1, 1'b0, 50, cyc);
      drain();
   endtask

   task automatic test_errors();
      int cyc;
      buf_ready = 1'b1;
      start_xfer(14'd3);
      drive_beats(0, 1, 3, 32'h200, 2, 1'b1, 1'b0, 20, cyc);
      checks++;
      if (dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL err_early: err=%b, required 0", dma_rd_err);
      end
      drive_beats(1, 1, 3, 32'h200, 2, 1'b1, 1'b0, 20, cyc);
      checks++;
      if (dma_rd_err !== 1'b1) begin
         errors++;
         $display("FAIL err_resp: err=%b, required 1", dma_rd_err);
      end
      drive_beats(2, 1, 3, 32'h200, 2, 1'b1, 1'b0, 20, cyc);
      tick(); tick();
      checks++;
      if (dma_rd_err !== 1'b1 || dma_axi_rdata_free !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b free=%b, required 1 1", dma_rd_err, dma_axi_rdata_free);
      end
      start_xfer(14'd2);
      checks++;
      if (dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b, required 0", dma_rd_err);
      end
      drive_beats(0, 2, 2, 32'h300, 0, 1'b0, 1'b0, 20, cyc);
      checks++;
      if (dma_rd_err !== 1'b1 || dma_axi_rdata_free !== 1'b1) begin
         errors++;
         $display("FAIL err_rlast: err=%b free=%b, required 1 1", dma_rd_err, dma_axi_rdata_free);
      end
      drain();
   endtask

   task automatic test_zero_and_ignored();
      int cyc;
      buf_ready = 1'b1;
      start_xfer(14'd0);
      tick();
      checks++;
      if (dma_axi_rdata_free !== 1'b1 || rready !== 1'b0 || dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL zero_start: free=%b rready=%b err=%b, required 1 0 0",
                  dma_axi_rdata_free, rready, dma_rd_err);
      end
      start_xfer(14'd4);
      drive_beats(0, 2, 4, 32'h400, 0, 1'b1, 1'b0, 20, cyc);
      dma_cfg_number = 14'd9;
      dma_axi_start  = 1'b1;
      drive_beats(2, 2, 4, 32'h400, 0, 1'b1, 1'b0, 20, cyc);
      for (int k = 0; k < 3; k++) begin
         rvalid = 1'b1; rdata = 32'hDEAD0000 + DATA_W'(k);
         @(negedge aclk);
         checks++;
         if (rready !== 1'b0 || dma_axi_rdata_free !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start: rready=%b free=%b, required 0 1", rready, dma_axi_rdata_free);
         end
         tick();
      end
      rvalid = 1'b0;
      drain();
   endtask

   task automatic test_wrap();
      int cyc;
      start_xfer(14'd40);
      drive_beats(0, 40, 40, 32'h500, 0, 1'b1, 1'b1, 2000, cyc);
      checks++;
      if (dma_axi_rdata_free !== 1'b1 || dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_done: free=%b err=%b, required 1 0", dma_axi_rdata_free, dma_rd_err);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int cyc;
      buf_ready = 1'b0;
      start_xfer(14'd10);
      drive_beats(0, 6, 10, 32'h600, 1, 1'b1, 1'b0, 20, cyc);
      buf_ready = 1'b1;
      tick(); tick(); tick();
      buf_ready = 1'b0;
      checks++;
      if (buf_count !== 3 || dma_rd_err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: count=%0d err=%b, required 3 1", buf_count, dma_rd_err);
      end
      areset = 1'b1;
      tick();
      checks++;
      if (rready !== 1'b0 || dma_axi_rdata_free !== 1'b1 || buf_count !== 0 ||
          buf_valid !== 1'b0 || dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rready=%b free=%b count=%0d valid=%b err=%b, required 0 1 0 0 0",
                  rready, dma_axi_rdata_free, buf_count, buf_valid, dma_rd_err);
      end
      areset = 1'b0;
      exp_q.delete();
      tick();
      buf_ready = 1'b1;
      start_xfer(14'd2);
      drive_beats(0, 2, 2, 32'h700, 0, 1'b1, 1'b0, 20, cyc);
      checks++;
      if (dma_axi_rdata_free !== 1'b1 || dma_rd_err !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: free=%b err=%b, required 1 0", dma_axi_rdata_free, dma_rd_err);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_errors();
      test_zero_and_ignored();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
